dbus_master: RTL and testbench

Synthesizable data-bus initiator for the CPU core: accepts one load/store request at a time from the MEM stage and drives the external data-memory bus. Bus signals are DAD, MREQ, WRITE, SIZE, DDT and ACKD_n. It formats store data, waits any number of cycles for ACKD_n, and sign- or zero-extends load data. It rejects misaligned or illegal accesses without issuing a bus cycle. It sits inside `top` between the datapath and the bus pins.

---
 rtl/dbus_pkg.sv | 36 +++
 rtl/dbus_master_if.sv | 38 +++
 rtl/dbus_load_ext.sv | 27 ++
 rtl/dbus_master.sv | 174 +++++++++++++++++
 tb/tb_dbus_master.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/dbus_pkg.sv
// Shared definitions for the data-bus initiator.
//   - SIZE_* : access size encodings, used on req_size and on the SIZE pins
//   - ERR_*  : completion status codes returned on resp_err
//   - state_e: initiator FSM states
//   - access_ok(): alignment/legality check applied when a request is accepted
package dbus_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBus  = 2'b01,
        StErr  = 2'b10
    } state_e;

    // True when the access may go out on the bus: naturally aligned and a
    // legal size.
    function automatic logic access_ok(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SIZE_WORD: ok = (addr_lo == 2'b00);
            SIZE_HALF: ok = ~addr_lo[0];
            SIZE_BYTE: ok = 1'b1;
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dbus_master_if.sv
// Request/response and bus-control signals of the data-bus initiator.
//   Request : req_valid, req_ready, req_write, req_size, req_signed, req_addr, req_wdata
//   Response: resp_valid, resp_rdata, resp_err
//   Bus     : DAD, MREQ, WRITE, SIZE (initiator driven), ACKD_n (memory driven)
// The bidirectional data bus DDT is a plain inout port on dbus_master.
// Modports: master = the initiator, slave = the MEM stage plus memory side.
interface dbus_master_if #(
    parameter int unsigned BIT_WIDTH = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [1:0]           req_size;
    logic                 req_signed;
    logic [BIT_WIDTH-1:0] req_addr;
    logic [BIT_WIDTH-1:0] req_wdata;

    logic                 resp_valid;
    logic [BIT_WIDTH-1:0] resp_rdata;
    logic [1:0]           resp_err;

    logic [BIT_WIDTH-1:0] DAD;
    logic                 MREQ;
    logic                 WRITE;
    logic [1:0]           SIZE;
    logic                 ACKD_n;

    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ACKD_n,
        output req_ready, resp_valid, resp_rdata, resp_err, DAD, MREQ, WRITE, SIZE
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ACKD_n,
        input  req_ready, resp_valid, resp_rdata, resp_err, DAD, MREQ, WRITE, SIZE
    );

endinterface

// File: rtl/dbus_load_ext.sv
// Load-data extender. Purely combinational; shared with the instruction-side
// fetch path.
//   size_i   : access size (SIZE_WORD / SIZE_HALF / SIZE_BYTE)
//   signed_i : 1 = sign-extend, 0 = zero-extend
//   data_i   : raw bus data, with the addressed lane already right-aligned by memory
//   data_o   : extended result
module dbus_load_ext
    import dbus_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 32
) (
    input  logic [1:0]           size_i,
    input  logic                 signed_i,
    input  logic [BIT_WIDTH-1:0] data_i,
    output logic [BIT_WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (size_i)
            SIZE_HALF: data_o = {{(BIT_WIDTH-16){signed_i & data_i[15]}}, data_i[15:0]};
            SIZE_BYTE: data_o = {{(BIT_WIDTH-8){signed_i & data_i[7]}}, data_i[7:0]};
            default:   data_o = data_i;
        endcase
    end

endmodule

// File: rtl/dbus_master.sv
// Data-bus initiator. Accepts one load/store at a time from the MEM stage,
// runs a single bus cycle on DAD/MREQ/WRITE/SIZE/DDT, waits for ACKD_n and
// returns a one-cycle completion pulse. Misaligned or illegal-size requests
// are answered with ERR_ALIGN without touching the bus.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : dbus_master_if.master (request, response and bus control)
//   DDT      : bidirectional bus data, driven only while MREQ & WRITE
// Optional feature (macro DBUS_TIMEOUT_EN): abort the bus cycle with
// ERR_TIMEOUT after TIMEOUT_CYCLES cycles without ACKD_n. Without the macro
// the initiator waits indefinitely.
module dbus_master
    import dbus_pkg::*;
#(
    parameter int unsigned BIT_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    dbus_master_if.master        bus,
    inout  wire  [BIT_WIDTH-1:0] DDT
);

    state_e               state_q, state_d;
    logic                 mreq_q, mreq_d;
    logic [BIT_WIDTH-1:0] addr_q;
    logic [1:0]           size_q;
    logic                 write_q;
    logic                 signed_q;
    logic [BIT_WIDTH-1:0] wdata_q;
    logic                 resp_valid_q, resp_valid_d;
    logic [BIT_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic [1:0]           resp_err_q, resp_err_d;

    logic                 accept;
    logic [BIT_WIDTH-1:0] store_data;
    logic [BIT_WIDTH-1:0] load_data;

`ifdef DBUS_TIMEOUT_EN
    localparam int unsigned WaitW =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYCLES - 1);

    logic [WaitW-1:0] wait_q, wait_d;
`endif

    assign accept = (state_q == StIdle) && bus.req_valid;

    // Store data is right-aligned; unused upper lanes are driven as zero.
    always_comb begin
        store_data = wdata_q;
        case (size_q)
            SIZE_HALF: store_data = BIT_WIDTH'(wdata_q[15:0]);
            SIZE_BYTE: store_data = BIT_WIDTH'(wdata_q[7:0]);
            default:   store_data = wdata_q;
        endcase
    end

    // Both enable terms are flops, so an async reset releases DDT at once.
    assign DDT = (mreq_q && write_q) ? store_data : {BIT_WIDTH{1'bz}};

    dbus_load_ext #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_load_ext (
        .size_i   (size_q),
        .signed_i (signed_q),
        .data_i   (DDT),
        .data_o   (load_data)
    );

    always_comb begin
        state_d      = state_q;
        mreq_d       = mreq_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = ERR_NONE;
`ifdef DBUS_TIMEOUT_EN
        wait_d       = wait_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    if (access_ok(bus.req_size, bus.req_addr[1:0])) begin
                        state_d = StBus;
                        mreq_d  = 1'b1;
`ifdef DBUS_TIMEOUT_EN
                        wait_d  = '0;
`endif
                    end else begin
                        // Response is raised together with entry to StErr so it
                        // appears in the first cycle after acceptance.
                        state_d      = StErr;
                        resp_valid_d = 1'b1;
                        resp_err_d   = ERR_ALIGN;
                    end
                end
            end
            StBus: begin
                if (!bus.ACKD_n) begin
                    state_d      = StIdle;
                    mreq_d       = 1'b0;
                    resp_valid_d = 1'b1;
                    if (!write_q) begin
                        resp_rdata_d = load_data;
                    end
`ifdef DBUS_TIMEOUT_EN
                end else if (wait_q == WaitLast) begin
                    state_d      = StIdle;
                    mreq_d       = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_TIMEOUT;
                end else begin
                    wait_d = wait_q + 1'b1;
`endif
                end
            end
            StErr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                mreq_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            mreq_q       <= 1'b0;
            addr_q       <= '0;
            size_q       <= SIZE_WORD;
            write_q      <= 1'b0;
            signed_q     <= 1'b0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            mreq_q       <= mreq_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            if (accept) begin
                addr_q   <= bus.req_addr;
                size_q   <= bus.req_size;
                write_q  <= bus.req_write;
                signed_q <= bus.req_signed;
                wdata_q  <= bus.req_wdata;
            end
        end
    end

`ifdef DBUS_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.DAD        = addr_q;
    assign bus.MREQ       = mreq_q;
    assign bus.WRITE      = write_q;
    assign bus.SIZE       = size_q;

endmodule

// File: tb/tb_dbus_master.sv
// Directed bench for dbus_master. A small memory model answers bus cycles
// after a programmed number of wait states; whenever MREQ is low it drives a
// probe pattern on DDT so that a released bus reads back the probe.
module tb_dbus_master;
    import dbus_pkg::*;

`ifdef DBUS_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif
    localparam logic [31:0] PROBE = 32'h5A5A_A5A5;

    logic        clk;
    logic        rst;
    logic        mem_drive;
    logic [31:0] mem_data;
    wire  [31:0] DDT;

    int n_vec;
    int n_err;

    dbus_master_if #(.BIT_WIDTH(32)) bus ();

    dbus_master #(
        .BIT_WIDTH      (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .DDT (DDT)
    );

    assign DDT = mem_drive ? mem_data : 32'hzzzz_zzzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", n_err);
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request issued at cycle T (task entry is just after a rising edge).
    // Memory pulls ACKD_n low in cycle T+waits+1; the task observes 'span'
    // cycles after T, then checks counts and the response.
    task automatic xfer(input string tag, input logic wr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] mem_rd, input int waits, input int span,
                        input int exp_mreq, input int exp_resp, input logic [31:0] exp_rdata,
                        input logic [1:0] exp_err, input logic [31:0] exp_ddt);
        int          n_mreq;
        int          n_resp;
        int          resp_c;
        logic        first;
        logic        rdy;
        logic [31:0] rdata;
        logic [1:0]  err;
        n_mreq = 0;
        n_resp = 0;
        resp_c = -1;
        first  = 1'b1;
        rdy    = 1'b0;
        rdata  = 32'hFFFF_FFFF;
        err    = 2'b11;

        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(negedge clk);
        check_val({tag, ".ready_idle"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;

        for (int c = 1; c <= span; c++) begin
            if (bus.MREQ && !bus.WRITE) begin
                mem_drive = 1'b1;
                mem_data  = mem_rd;
            end else if (!bus.MREQ) begin
                mem_drive = 1'b1;
                mem_data  = PROBE;
            end else begin
                mem_drive = 1'b0;
            end
            bus.ACKD_n = !(bus.MREQ && (c == waits + 1));
            @(negedge clk);
            if (bus.MREQ) begin
                n_mreq++;
                if (first) begin
                    first = 1'b0;
                    check_val({tag, ".dad"}, bus.DAD, addr);
                    check_val({tag, ".wr_size"}, {29'd0, bus.WRITE, bus.SIZE}, {29'd0, wr, size});
                    if (wr) check_val({tag, ".ddt_store"}, DDT, exp_ddt);
                end
            end
            if (bus.resp_valid) begin
                n_resp++;
                resp_c = c;
                rdata  = bus.resp_rdata;
                err    = bus.resp_err;
                rdy    = bus.req_ready;
                check_val({tag, ".ddt_released"}, DDT, PROBE);
            end
            @(posedge clk);
            #1;
        end
        bus.ACKD_n = 1'b1;

        check_val({tag, ".mreq_cycles"}, 32'(n_mreq), 32'(exp_mreq));
        check_val({tag, ".resp_pulses"}, 32'(n_resp), 32'd1);
        check_val({tag, ".resp_cycle"}, 32'(resp_c), 32'(exp_resp));
        check_val({tag, ".rdata"}, rdata, exp_rdata);
        check_val({tag, ".err"}, 32'(err), 32'(exp_err));
        if (exp_err == ERR_NONE) check_val({tag, ".ready_resp"}, 32'(rdy), 32'd1);
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst            = 1'b1;
        mem_drive      = 1'b1;
        mem_data       = PROBE;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.ACKD_n     = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst.ctrl",
                  {26'd0, bus.req_ready, bus.MREQ, bus.WRITE, bus.SIZE, bus.resp_valid},
                  {26'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0});
        check_val("rst.dad", bus.DAD, 32'h0);
        check_val("rst.rdata", bus.resp_rdata, 32'h0);
        check_val("rst.err", 32'(bus.resp_err), 32'd0);
        check_val("rst.ddt", DDT, PROBE);
        @(posedge clk);
        #1;

        // tag              wr    size       sgn   addr          wdata         mem_rd       w  sp  mq rs rdata         err        ddt
        xfer("ld_word",     1'b0, SIZE_WORD, 1'b0, 32'h0800_0004, 32'h0,       32'hDEAD_BEEF, 0, 3, 1, 2, 32'hDEAD_BEEF, ERR_NONE, 32'h0);
        xfer("ld_sbyte",    1'b0, SIZE_BYTE, 1'b1, 32'h0800_0003, 32'h0,       32'h0000_0080, 0, 3, 1, 2, 32'hFFFF_FF80, ERR_NONE, 32'h0);
        xfer("ld_ubyte",    1'b0, SIZE_BYTE, 1'b0, 32'h0800_0003, 32'h0,       32'h0000_0080, 0, 3, 1, 2, 32'h0000_0080, ERR_NONE, 32'h0);
        xfer("ld_shalf",    1'b0, SIZE_HALF, 1'b1, 32'h0800_0002, 32'h0,       32'h0000_8001, 1, 4, 2, 3, 32'hFFFF_8001, ERR_NONE, 32'h0);
        xfer("ld_shalf_pos",1'b0, SIZE_HALF, 1'b1, 32'h0800_0000, 32'h0,       32'h1234_7FFF, 0, 3, 1, 2, 32'h0000_7FFF, ERR_NONE, 32'h0);
        xfer("st_half",     1'b1, SIZE_HALF, 1'b0, 32'h0800_0002, 32'h1234_ABCD, 32'h0,      0, 3, 1, 2, 32'h0,         ERR_NONE, 32'h0000_ABCD);
        xfer("st_byte",     1'b1, SIZE_BYTE, 1'b0, 32'h0800_0001, 32'h1234_56EF, 32'h0,      2, 5, 3, 4, 32'h0,         ERR_NONE, 32'h0000_00EF);
        xfer("st_word",     1'b1, SIZE_WORD, 1'b0, 32'h0800_0008, 32'h1234_5678, 32'h0,      1, 4, 2, 3, 32'h0,         ERR_NONE, 32'h1234_5678);
        xfer("mis_word",    1'b0, SIZE_WORD, 1'b0, 32'h0800_0002, 32'h0,       32'hDEAD_BEEF, 0, 2, 0, 1, 32'h0,         ERR_ALIGN, 32'h0);
        xfer("mis_half",    1'b1, SIZE_HALF, 1'b0, 32'h0800_0001, 32'hFFFF_FFFF, 32'h0,      0, 2, 0, 1, 32'h0,         ERR_ALIGN, 32'h0);
        xfer("ill_size",    1'b0, SIZE_ILL,  1'b0, 32'h0800_0000, 32'h0,       32'hDEAD_BEEF, 0, 2, 0, 1, 32'h0,         ERR_ALIGN, 32'h0);
`ifdef DBUS_TIMEOUT_EN
        xfer("wait5_to",    1'b0, SIZE_WORD, 1'b0, 32'h0800_0010, 32'h0,       32'hA5A5_0F0F, 5, 8, 4, 5, 32'h0,         ERR_TIMEOUT, 32'h0);
        xfer("ack_at_lim",  1'b0, SIZE_WORD, 1'b0, 32'h0800_0014, 32'h0,       32'h0F0F_A5A5, 3, 6, 4, 5, 32'h0F0F_A5A5, ERR_NONE, 32'h0);
`else
        xfer("wait5",       1'b0, SIZE_WORD, 1'b0, 32'h0800_0010, 32'h0,       32'hA5A5_0F0F, 5, 8, 6, 7, 32'hA5A5_0F0F, ERR_NONE, 32'h0);
`endif

        // Async reset in the 3rd bus cycle of a word store.
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_size   = SIZE_WORD;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0800_0020;
        bus.req_wdata  = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        mem_drive     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("arst.mreq_before", 32'(bus.MREQ), 32'd1);
        check_val("arst.ddt_before", DDT, 32'hCAFE_F00D);
        #2;
        rst       = 1'b1;
        mem_drive = 1'b1;
        mem_data  = PROBE;
        #1;
        check_val("arst.mreq_now", 32'(bus.MREQ), 32'd0);
        check_val("arst.ddt_now", DDT, PROBE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("arst.resp_valid", 32'(bus.resp_valid), 32'd0);
        check_val("arst.ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        check_val("arst.resp_valid2", 32'(bus.resp_valid), 32'd0);
        check_val("arst.mreq_after", 32'(bus.MREQ), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
